// File: rtl/aes_round_iter.sv
// Iterative AES encryption core: one cipher round per clock on a registered 128-bit state.
// Round keys are looked up externally via round_key_idx; MixColumns is skipped in the last round.
module aes_round_iter #(
    parameter int NK__KEY_LENGTH           = 8,
    parameter int NB__BLOCK_LENGTH_IN_TEXT = 4,
    localparam int NR__ROUNDS              = NK__KEY_LENGTH + 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   round_key_idx,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic [3:0]   round_number_out
);

    localparam logic [3:0] LAST_RND = 4'(NR__ROUNDS);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    if (!(NK__KEY_LENGTH == 4 || NK__KEY_LENGTH == 6 || NK__KEY_LENGTH == 8) ||
        NB__BLOCK_LENGTH_IN_TEXT != 4) begin : g_param_check
        $error("aes_round_iter: NK must be 4/6/8 and NB must be 4");
    end

    // Byte 0 of the table sits in the top bits, so the offset of entry x is (255-x)*8 = {~x,3'b0}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned row = 0; row < 4; row++) begin
                r[8*(15-(4*c+row)) +: 8] = sbox(s[8*(15-(4*((c+row)%4)+row)) +: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [31:0]  col;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            col = s[32*(3-c) +: 32];
            a0  = col[31:24];
            a1  = col[23:16];
            a2  = col[15:8];
            a3  = col[7:0];
            r[32*(3-c) +: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] data_q, data_d;
    logic [127:0] out_q, out_d;
    logic [127:0] ss;

    always_comb begin
        fsm_d         = fsm_q;
        rnd_d         = rnd_q;
        data_d        = data_q;
        out_d         = out_q;
        in_ready      = 1'b0;
        round_key_idx = '0;
        ss            = sub_shift(data_q);
        case (fsm_q)
            S_IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    data_d = in_block ^ round_key;
                    rnd_d  = 4'd1;
                    fsm_d  = S_RUN;
                end
            end
            S_RUN: begin
                round_key_idx = rnd_q;
                if (rnd_q == LAST_RND) begin
                    out_d = ss ^ round_key;
                    fsm_d = S_DONE;
                end else begin
                    data_d = mix_columns(ss) ^ round_key;
                    rnd_d  = rnd_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    rnd_d = '0;
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= S_IDLE;
            rnd_q  <= '0;
            data_q <= '0;
            out_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            rnd_q  <= rnd_d;
            data_q <= data_d;
            out_q  <= out_d;
        end
    end

    assign out_valid        = (fsm_q == S_DONE);
    assign out_block        = out_q;
    assign round_number_out = rnd_q;

endmodule
